bitfusion_mac_pe: RTL

Parametrised bit-fusion multiply-accumulate processing element with a registered input stage, a runtime-selectable operand precision of 8, 4 or 2 bits, and a per-job accumulation counter. Each job accepts `len` operand beats over a valid/ready stream and sums the lane-wise products of every beat into a single ACC_W-bit partial sum. The block presents that partial sum on a valid/ready output port. It sits in a systolic column as the compute node between the operand/weight buffers and the partial-sum forwarding path.

---
 rtl/bitfusion_mac_pe.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bitfusion_mac_pe.sv
// bitfusion_mac_pe: bit-fusion multiply-accumulate processing element.
// Runtime precision of 8, 4 or 2 bits per lane, with a 3-stage pipeline
// (operand register, lane-product sum, accumulate) and a per-job beat counter.
// Optional macro BF_ACC_SAT_EN: when defined, the accumulator saturates
// instead of wrapping modulo 2^ACC_W.
module bitfusion_mac_pe #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             s_in,
  input  logic             s_weight,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [7:0]       weight_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_psum,
  output logic             busy
);

  // 9x9 signed lane product, largest possible beat sum fits in 18 bits
  localparam int unsigned PROD_W  = 18;
  localparam int unsigned SUM_W   = ACC_W + 4;
  localparam int unsigned DRAIN_W = 2;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t             state;
  logic [1:0]         mode_q;
  logic               s_in_q;
  logic               s_w_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [DRAIN_W-1:0] drain_cnt;

  logic               s1_valid;
  logic [7:0]         s1_in;
  logic [7:0]         s1_w;
  logic               s2_valid;
  logic signed [PROD_W-1:0] s2_prod;
  logic [ACC_W-1:0]   acc;

  logic               accept_c;
  logic               start_ok_c;
  logic               signed_any_c;
  logic signed [PROD_W-1:0] prod_c;
  logic [ACC_W-1:0]   acc_nxt_c;

  assign accept_c     = in_valid & in_ready;
  assign start_ok_c   = (state == IDLE) && start && (mode != 2'b11) && (len != '0);
  assign signed_any_c = s_in_q | s_w_q;

  // Lane operand extension to a common 9-bit signed form
  function automatic logic signed [8:0] ext8(input logic [7:0] x, input logic s);
    return {s & x[7], x};
  endfunction

  function automatic logic signed [8:0] ext4(input logic [3:0] x, input logic s);
    return {{5{s & x[3]}}, x};
  endfunction

  function automatic logic signed [8:0] ext2(input logic [1:0] x, input logic s);
    return {{7{s & x[1]}}, x};
  endfunction

  function automatic logic signed [PROD_W-1:0] mul9(input logic signed [8:0] a,
                                                    input logic signed [8:0] b);
    logic signed [PROD_W-1:0] aw;
    logic signed [PROD_W-1:0] bw;
    aw = PROD_W'(a);
    bw = PROD_W'(b);
    return aw * bw;
  endfunction

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= '0;
      s_in_q    <= 1'b0;
      s_w_q     <= 1'b0;
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_psum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok_c) begin
            mode_q   <= mode;
            s_in_q   <= s_in;
            s_w_q    <= s_weight;
            len_q    <= len;
            beat_cnt <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (accept_c) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (beat_cnt == len_q - LEN_W'(1)) begin
              in_ready  <= 1'b0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Last beat still has stage 2 and stage 3 to traverse
          if (drain_cnt == DRAIN_LAST) begin
            out_psum  <= acc;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: capture operands of each accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_in    <= '0;
      s1_w     <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_in <= in_data;
        s1_w  <= weight_data;
      end
    end
  end

  // Lane split and sum of lane products for the latched precision
  always_comb begin
    prod_c = '0;
    case (mode_q)
      2'b01: begin
        for (int i = 0; i < 2; i++) begin
          prod_c = prod_c + mul9(ext4(s1_in[4*i +: 4], s_in_q),
                                 ext4(s1_w[4*i +: 4], s_w_q));
        end
      end
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          prod_c = prod_c + mul9(ext2(s1_in[2*i +: 2], s_in_q),
                                 ext2(s1_w[2*i +: 2], s_w_q));
        end
      end
      default: prod_c = mul9(ext8(s1_in, s_in_q), ext8(s1_w, s_w_q));
    endcase
  end

  // Stage 2: register the beat product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= prod_c;
      end
    end
  end

`ifdef BF_ACC_SAT_EN
  localparam logic [SUM_W-1:0] SMAX = {5'b00000, {(ACC_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] SMIN = {5'b11111, {(ACC_W-1){1'b0}}};

  logic [SUM_W-1:0] acc_x_c;
  logic [SUM_W-1:0] prod_x_c;
  logic [SUM_W-1:0] sum_c;

  // Saturating accumulate on a widened sum, clamp range set by signedness
  always_comb begin
    acc_x_c  = signed_any_c ? SUM_W'($signed(acc)) : SUM_W'(acc);
    prod_x_c = signed_any_c ? SUM_W'(s2_prod) : SUM_W'($unsigned(s2_prod));
    sum_c    = acc_x_c + prod_x_c;
    acc_nxt_c = sum_c[ACC_W-1:0];
    if (signed_any_c) begin
      if ($signed(sum_c) > $signed(SMAX)) begin
        acc_nxt_c = {1'b0, {(ACC_W-1){1'b1}}};
      end else if ($signed(sum_c) < $signed(SMIN)) begin
        acc_nxt_c = {1'b1, {(ACC_W-1){1'b0}}};
      end
    end else if (|sum_c[SUM_W-1:ACC_W]) begin
      acc_nxt_c = '1;
    end
  end
`else
  logic [ACC_W-1:0] prod_ext_c;

  // Wrapping accumulate modulo 2^ACC_W
  always_comb begin
    prod_ext_c = signed_any_c ? ACC_W'(s2_prod) : ACC_W'($unsigned(s2_prod));
    acc_nxt_c  = acc + prod_ext_c;
  end
`endif

  // Stage 3: accumulator, cleared when a job is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (start_ok_c) begin
      acc <= '0;
    end else if (s2_valid) begin
      acc <= acc_nxt_c;
    end
  end

endmodule
